// File: rtl/store_queue_fwd_if.sv
// store_queue_fwd_if: allocate/commit, load-lookup and memory-drain signals of the store queue.
// The flush signal exists only when SQ_FLUSH_EN is defined.
interface store_queue_fwd_if #(
  parameter int DEPTH = 8,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = $clog2(DEPTH) + 1
);
  logic enq0_valid, enq1_valid;
  logic [AW-1:0] enq0_addr, enq1_addr;
  logic [DW-1:0] enq0_data, enq1_data;
  logic commit0, commit1;
`ifdef SQ_FLUSH_EN
  logic flush;
`endif
  logic ld0_valid, ld1_valid;
  logic [AW-1:0] ld0_addr, ld1_addr;
  logic ld0_done, ld1_done, ld0_hit, ld1_hit;
  logic [DW-1:0] ld0_data, ld1_data;
  logic mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic full, empty, ovf_err;
  logic [CW-1:0] count;
`ifdef SQ_FLUSH_EN
  modport master(
    output enq0_valid, enq1_valid, enq0_addr, enq1_addr, enq0_data, enq1_data, commit0, commit1, flush,
    output ld0_valid, ld1_valid, ld0_addr, ld1_addr, mem_ready,
    input ld0_done, ld1_done, ld0_hit, ld1_hit, ld0_data, ld1_data,
    input mem_valid, mem_addr, mem_data, full, empty, ovf_err, count
  );
  modport slave(
    input enq0_valid, enq1_valid, enq0_addr, enq1_addr, enq0_data, enq1_data, commit0, commit1, flush,
    input ld0_valid, ld1_valid, ld0_addr, ld1_addr, mem_ready,
    output ld0_done, ld1_done, ld0_hit, ld1_hit, ld0_data, ld1_data,
    output mem_valid, mem_addr, mem_data, full, empty, ovf_err, count
  );
`else
  modport master(
    output enq0_valid, enq1_valid, enq0_addr, enq1_addr, enq0_data, enq1_data, commit0, commit1,
    output ld0_valid, ld1_valid, ld0_addr, ld1_addr, mem_ready,
    input ld0_done, ld1_done, ld0_hit, ld1_hit, ld0_data, ld1_data,
    input mem_valid, mem_addr, mem_data, full, empty, ovf_err, count
  );
  modport slave(
    input enq0_valid, enq1_valid, enq0_addr, enq1_addr, enq0_data, enq1_data, commit0, commit1,
    input ld0_valid, ld1_valid, ld0_addr, ld1_addr, mem_ready,
    output ld0_done, ld1_done, ld0_hit, ld1_hit, ld0_data, ld1_data,
    output mem_valid, mem_addr, mem_data, full, empty, ovf_err, count
  );
`endif
endinterface

// File: rtl/store_queue_fwd.sv
// store_queue_fwd: in-order store queue, 2-wide allocate/commit, 1-wide drain, 2 forwarding lookups.
// Define SQ_FLUSH_EN to add the flush port that discards all pending stores.
module store_queue_fwd #(
  parameter int DEPTH = 8,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  store_queue_fwd_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, cptr, tail;
  logic [CW-1:0] cnt, ccnt, pend, free, creq, ncom, nenq, nccnt, ncnt;
  logic fl, drain, e0_ok, e1_ok, c_err, e_err, hit0, hit1;
  logic [DW-1:0] fd0, fd1;
`ifdef SQ_FLUSH_EN
  assign fl = bus.flush;
`else
  assign fl = 1'b0;
`endif
  // free slots ignore the same-cycle drain; flush drops enqueues without error
  always_comb begin
    pend = cnt - ccnt;
    free = CW'(DEPTH) - cnt;
    creq = bus.commit0 ? (bus.commit1 ? CW'(2) : CW'(1)) : '0;
    ncom = creq > pend ? pend : creq;
    c_err = (bus.commit1 && !bus.commit0) || creq > pend;
    e0_ok = bus.enq0_valid && free != '0 && !fl;
    e1_ok = bus.enq1_valid && bus.enq0_valid && free >= CW'(2) && !fl;
    e_err = !fl && ((bus.enq0_valid && !e0_ok) || (bus.enq1_valid && !e1_ok));
    nenq = CW'(e0_ok) + CW'(e1_ok);
    drain = ccnt != '0 && bus.mem_ready;
    nccnt = ccnt + ncom - CW'(drain);
    ncnt = fl ? nccnt : cnt + nenq - CW'(drain);
  end
  // scan oldest to youngest so the youngest match is left standing
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    fd0 = '0;
    fd1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt && addr_q[head + PW'(i)] == bus.ld0_addr) begin
        hit0 = 1'b1;
        fd0 = data_q[head + PW'(i)];
      end
      if (CW'(i) < cnt && addr_q[head + PW'(i)] == bus.ld1_addr) begin
        hit1 = 1'b1;
        fd1 = data_q[head + PW'(i)];
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head <= '0;
      cptr <= '0;
      tail <= '0;
      cnt <= '0;
      ccnt <= '0;
      bus.ovf_err <= 1'b0;
      bus.ld0_done <= 1'b0;
      bus.ld1_done <= 1'b0;
      bus.ld0_hit <= 1'b0;
      bus.ld1_hit <= 1'b0;
      bus.ld0_data <= '0;
      bus.ld1_data <= '0;
    end else begin
      if (e0_ok) begin
        addr_q[tail] <= bus.enq0_addr;
        data_q[tail] <= bus.enq0_data;
      end
      if (e1_ok) begin
        addr_q[tail + PW'(1)] <= bus.enq1_addr;
        data_q[tail + PW'(1)] <= bus.enq1_data;
      end
      head <= head + PW'(drain);
      cptr <= cptr + PW'(ncom);
      tail <= fl ? cptr + PW'(ncom) : tail + PW'(nenq);
      cnt <= ncnt;
      ccnt <= nccnt;
      bus.ovf_err <= bus.ovf_err | c_err | e_err;
      bus.ld0_done <= bus.ld0_valid;
      bus.ld1_done <= bus.ld1_valid;
      bus.ld0_hit <= bus.ld0_valid & hit0;
      bus.ld1_hit <= bus.ld1_valid & hit1;
      bus.ld0_data <= bus.ld0_valid ? fd0 : '0;
      bus.ld1_data <= bus.ld1_valid ? fd1 : '0;
    end
  assign bus.mem_valid = ccnt != '0;
  assign bus.mem_addr = addr_q[head];
  assign bus.mem_data = data_q[head];
  assign bus.full = cnt > CW'(DEPTH - 2);
  assign bus.empty = cnt == '0;
  assign bus.count = cnt;
endmodule

// File: tb/tb_store_queue_fwd.sv
// tb_store_queue_fwd: directed and random stimulus checked against a queue-based store model.
module tb_store_queue_fwd;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_r = 1'b0;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit c;
  } ent_t;
  ent_t q[$];
  bit m_ovf = 0;
  bit e_hit0, e_hit1, e_ld0, e_ld1;
  logic [31:0] e_d0, e_d1;
  store_queue_fwd_if #(.DEPTH(DEPTH)) sq();
  store_queue_fwd #(.DEPTH(DEPTH)) dut(.clk(clk), .rst(rst), .bus(sq));
`ifdef SQ_FLUSH_EN
  assign sq.flush = flush_r;
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sq.enq0_valid = 0; sq.enq1_valid = 0; sq.enq0_addr = 0; sq.enq1_addr = 0;
    sq.enq0_data = 0; sq.enq1_data = 0; sq.commit0 = 0; sq.commit1 = 0;
    sq.ld0_valid = 0; sq.ld1_valid = 0; sq.ld0_addr = 0; sq.ld1_addr = 0;
    sq.mem_ready = 0; flush_r = 0;
  endtask

  task automatic enq(input bit two, input logic [31:0] a0, d0, a1, d1);
    sq.enq0_valid = 1; sq.enq0_addr = a0; sq.enq0_data = d0;
    sq.enq1_valid = two; sq.enq1_addr = a1; sq.enq1_data = d1;
  endtask

  // advance the model by one clock with the currently driven inputs, then compare
  task automatic step();
    int n, nc, creq, free;
    bit dr;
    ent_t e;
    n = q.size();
    nc = 0;
    foreach (q[i]) if (q[i].c) nc++;
    e_hit0 = 0; e_hit1 = 0; e_d0 = 0; e_d1 = 0;
    for (int i = 0; i < n; i++) begin
      if (q[i].a == sq.ld0_addr) begin e_hit0 = 1; e_d0 = q[i].d; end
      if (q[i].a == sq.ld1_addr) begin e_hit1 = 1; e_d1 = q[i].d; end
    end
    e_ld0 = sq.ld0_valid; e_ld1 = sq.ld1_valid;
    if (!e_ld0) begin e_hit0 = 0; e_d0 = 0; end
    if (!e_ld1) begin e_hit1 = 0; e_d1 = 0; end
    dr = nc > 0 && sq.mem_ready;
    creq = sq.commit0 ? (sq.commit1 ? 2 : 1) : 0;
    if (creq > n - nc) begin m_ovf = 1; creq = n - nc; end
    for (int i = nc; i < nc + creq; i++) q[i].c = 1;
    free = DEPTH - n;
    if (flush_r) begin
      while (q.size() > 0 && !q[q.size()-1].c) void'(q.pop_back());
    end else begin
      if (sq.enq0_valid) begin
        if (free >= 1) begin e.a = sq.enq0_addr; e.d = sq.enq0_data; e.c = 0; q.push_back(e); end
        else m_ovf = 1;
      end
      if (sq.enq1_valid) begin
        if (sq.enq0_valid && free >= 2) begin e.a = sq.enq1_addr; e.d = sq.enq1_data; e.c = 0; q.push_back(e); end
        else m_ovf = 1;
      end
    end
    if (dr) void'(q.pop_front());
    @(posedge clk);
    #1;
    chk("count", sq.count, q.size());
    chk("empty", sq.empty, q.size() == 0);
    chk("full", sq.full, q.size() > DEPTH - 2);
    chk("mem_valid", sq.mem_valid, q.size() > 0 && q[0].c);
    if (q.size() > 0 && q[0].c) begin
      chk("mem_addr", sq.mem_addr, q[0].a);
      chk("mem_data", sq.mem_data, q[0].d);
    end
    chk("ovf_err", sq.ovf_err, m_ovf);
    chk("ld0_done", sq.ld0_done, e_ld0);
    chk("ld0_hit", sq.ld0_hit, e_hit0);
    chk("ld0_data", sq.ld0_data, e_d0);
    chk("ld1_done", sq.ld1_done, e_ld1);
    chk("ld1_hit", sq.ld1_hit, e_hit1);
    chk("ld1_data", sq.ld1_data, e_d1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, sq.count, 0);
    chk({tag, "_empty"}, sq.empty, 1);
    chk({tag, "_full"}, sq.full, 0);
    chk({tag, "_mem_valid"}, sq.mem_valid, 0);
    chk({tag, "_mem_addr"}, sq.mem_addr, 0);
    chk({tag, "_mem_data"}, sq.mem_data, 0);
    chk({tag, "_ovf"}, sq.ovf_err, 0);
    chk({tag, "_ld"}, {sq.ld0_done, sq.ld0_hit, sq.ld1_done, sq.ld1_hit}, 0);
    chk({tag, "_ld_data"}, {sq.ld0_data, sq.ld1_data}, 0);
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1;
    enq(1, 'h100, 'hAA, 'h104, 'hBB);
    step();
    clr();
    chk("t1_count", sq.count, 2);
    chk("t1_empty", sq.empty, 0);
    chk("t1_mem_valid", sq.mem_valid, 0);
    enq(0, 'h100, 'h11, 0, 0);
    step();
    enq(0, 'h100, 'h22, 0, 0);
    step();
    clr();
    sq.ld0_valid = 1; sq.ld0_addr = 'h100;
    sq.ld1_valid = 1; sq.ld1_addr = 'h200;
    step();
    clr();
    chk("fwd_hit", sq.ld0_hit, 1);
    chk("fwd_data", sq.ld0_data, 'h22);
    chk("miss_hit", sq.ld1_hit, 0);
    chk("miss_data", sq.ld1_data, 0);
    sq.commit0 = 1; sq.commit1 = 1; sq.mem_ready = 1;
    step();
    chk("drain_first", sq.mem_addr, 'h100);
    step();
    chk("drain_second", sq.mem_addr, 'h104);
    for (int i = 0; i < 6 && q.size() > 0; i++) step();
    clr();
    chk("drained_empty", sq.count, 0);
    for (int i = 0; i < 4; i++) begin
      enq(1, 'h200 + 8 * i, 'h50 + i, 'h204 + 8 * i, 'h60 + i);
      step();
    end
    clr();
    chk("fill_full", sq.full, 1);
    sq.enq0_valid = 1; sq.enq0_addr = 'h300; sq.enq0_data = 'h77;
    step();
    clr();
    chk("over_ovf", sq.ovf_err, 1);
    chk("over_count", sq.count, 8);
    sq.commit0 = 1; sq.commit1 = 1; sq.mem_ready = 1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      if (i == 4) sq.commit0 = 0;
      if (i == 4) sq.commit1 = 0;
      step();
    end
    clr();
    chk("wrap_empty", sq.empty, 1);
    enq(0, 'h100, 'h99, 0, 0);
    step();
    clr();
    sq.commit0 = 1;
    step();
    clr();
    chk("pre_rst_valid", sq.mem_valid, 1);
    #3;
    rst = 0;
    #1;
    chk_zero("async_rst");
    q.delete();
    m_ovf = 0;
    #2;
    rst = 1;
    sq.ld0_valid = 1; sq.ld0_addr = 'h100;
    step();
    clr();
    chk("post_rst_hit", sq.ld0_hit, 0);
`ifdef SQ_FLUSH_EN
    enq(1, 'h400, 'h1, 'h404, 'h2);
    step();
    enq(1, 'h408, 'h3, 'h40c, 'h4);
    step();
    clr();
    sq.commit0 = 1;
    step();
    clr();
    flush_r = 1;
    sq.enq0_valid = 1; sq.enq0_addr = 'h500; sq.enq0_data = 'h5;
    sq.ld0_valid = 1; sq.ld0_addr = 'h40c;
    step();
    clr();
    chk("flush_count", sq.count, 1);
    chk("flush_ovf", sq.ovf_err, 0);
    chk("flush_sees_pre", sq.ld0_hit, 1);
    chk("flush_head", sq.mem_addr, 'h400);
    sq.mem_ready = 1;
    step();
    step();
    clr();
    chk("flush_empty", sq.empty, 1);
`endif
    repeat (400) begin
      clr();
      sq.enq0_valid = $urandom_range(0, 1);
      sq.enq1_valid = sq.enq0_valid & 1'($urandom_range(0, 1));
      sq.enq0_addr = 'h100 + 4 * $urandom_range(0, 3);
      sq.enq1_addr = 'h100 + 4 * $urandom_range(0, 3);
      sq.enq0_data = $urandom;
      sq.enq1_data = $urandom;
      sq.commit0 = $urandom_range(0, 1);
      sq.commit1 = sq.commit0 & 1'($urandom_range(0, 1));
      sq.mem_ready = $urandom_range(0, 3) != 0;
      sq.ld0_valid = $urandom_range(0, 1);
      sq.ld1_valid = $urandom_range(0, 1);
      sq.ld0_addr = 'h100 + 4 * $urandom_range(0, 4);
      sq.ld1_addr = 'h100 + 4 * $urandom_range(0, 4);
`ifdef SQ_FLUSH_EN
      flush_r = $urandom_range(0, 15) == 0;
`endif
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
